multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, opcode width in bits.
REQ-002 SHALL have parameters R_LO/R_HI, defaults 1/8, inclusive R-type opcode range.
REQ-003 SHALL have parameters I_LO/I_HI, defaults 9/11, inclusive I-type opcode range.
REQ-004 SHALL have parameters BR_LO/BR_HI, defaults 12/14, inclusive branch opcode range.
REQ-005 SHALL have parameter JMP_OP, default 15, the single jump opcode.
REQ-006 SHALL have parameter CNT_W, default 16, retired-instruction counter width.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-009 SHALL have ports instr_valid (input, 1) and instr_ready (output, 1), the instruction handshake.
REQ-010 SHALL have port opcode, input, OPCODE_W, sampled only on handshake.
REQ-011 SHALL have port branch_taken, input, 1, the ALU condition result.
REQ-012 SHALL have port mem_ready, input, 1, data-memory write acknowledge.
REQ-013 SHALL have outputs branch_en, jump_en, immediate_en, write_en, pc_inc, pc_load, illegal, each 1 bit.
REQ-014 SHALL have output instr_count, CNT_W bits, retired-instruction count.

Function
REQ-015 SHALL implement FSM states IDLE, DECODE, EXEC, WB.
REQ-016 SHALL drive instr_ready=1 only in IDLE; accept occurs when instr_valid && instr_ready; IDLE->DECODE on accept, opcode registered.
REQ-017 SHALL ignore instr_valid outside IDLE; opcode changes after accept have no effect.
REQ-018 SHALL classify the registered opcode in DECODE as R, I, BR, JMP or ILLEGAL (opcode 0 or outside all ranges); range check precedence JMP, BR, I, R.
REQ-019 SHALL, for ILLEGAL, pulse illegal for one cycle in DECODE and return to IDLE; no count increment, no PC action.
REQ-020 SHALL move DECODE->EXEC for legal classes.
REQ-021 SHALL, in EXEC, assert immediate_en for I, branch_en for BR, jump_en for JMP; all zero for R.
REQ-022 SHALL, for R/I, go EXEC->WB.
REQ-023 SHALL, for BR, sample branch_taken in EXEC: taken -> pc_load=1, else pc_inc=1, same cycle; EXEC->IDLE.
REQ-024 SHALL, for JMP, assert pc_load=1 in EXEC; EXEC->IDLE.
REQ-025 SHALL hold write_en=1 throughout WB, with immediate_en held as in EXEC; stay in WB until mem_ready=1.
REQ-026 SHALL, in the WB cycle where mem_ready=1, assert pc_inc=1 and go WB->IDLE; mem_ready seen on the first WB cycle gives one-cycle WB.
REQ-027 SHALL ignore mem_ready outside WB.
REQ-028 SHALL increment instr_count by 1 on the cycle a legal instruction leaves EXEC (BR/JMP) or WB (R/I), wrapping from 2^CNT_W-1 to 0.
REQ-029 SHALL give minimum accept-to-retire latency: R/I 4 cycles (IDLE, DECODE, EXEC, WB), BR/JMP 3 cycles.
REQ-030 SHALL never assert pc_inc and pc_load together, nor write_en outside WB.

Reset
REQ-031 SHALL, on rising clk with rst=1, force state IDLE, instr_count 0, registered opcode 0.
REQ-032 SHALL hold all 1-bit outputs, instr_ready included, at 0 while rst=1; instr_ready rises the first cycle after rst falls.
REQ-033 SHALL, on reset mid-operation (any state), abandon the instruction: no count, no PC action, write_en drops in the reset cycle.

Structure
REQ-034 SHALL take the state enum, instruction-class enum and default range constants from shared package ctrl_pkg.
REQ-035 SHALL place opcode decoding in combinational sub-module opcode_classifier, parametrised identically, output instruction class.

Verification
REQ-036 SHALL cover: reset, then opcode=3 accepted, mem_ready=1 -> write_en=1 for one cycle in WB, pc_inc in same cycle, instr_count=1, 4-cycle latency.
REQ-037 SHALL cover: opcode=10, mem_ready held low 3 WB cycles -> immediate_en and write_en held 4 cycles, retire on 4th WB cycle.
REQ-038 SHALL cover: opcode=13 with branch_taken=1 then branch_taken=0 -> pc_load then pc_inc pulses, branch_en high in EXEC only.
REQ-039 SHALL cover: opcode=15 -> jump_en and pc_load in EXEC; opcode=0 -> illegal one-cycle pulse, instr_count unchanged.
REQ-040 SHALL cover: rst asserted during WB -> write_en 0, state IDLE, count 0; CNT_W=4 with 16 retires -> count wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and default opcode map for the multicycle control unit.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_BR      = 3'd2,
    CLS_JMP     = 3'd3,
    CLS_ILLEGAL = 3'd4
  } instr_class_t;

  localparam int OPCODE_W_DEF = 4;
  localparam int R_LO_DEF     = 1;
  localparam int R_HI_DEF     = 8;
  localparam int I_LO_DEF     = 9;
  localparam int I_HI_DEF     = 11;
  localparam int BR_LO_DEF    = 12;
  localparam int BR_HI_DEF    = 14;
  localparam int JMP_OP_DEF   = 15;
  localparam int CNT_W_DEF    = 16;

  function automatic logic in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode-to-class decoder; opcode 0 is always illegal.
module opcode_classifier
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int R_LO     = R_LO_DEF,
  parameter int R_HI     = R_HI_DEF,
  parameter int I_LO     = I_LO_DEF,
  parameter int I_HI     = I_HI_DEF,
  parameter int BR_LO    = BR_LO_DEF,
  parameter int BR_HI    = BR_HI_DEF,
  parameter int JMP_OP   = JMP_OP_DEF
) (
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        instr_class
);

  int op_value;

  // Priority range match: JMP, then BR, then I, then R.
  always_comb begin
    op_value    = int'(opcode);
    instr_class = CLS_ILLEGAL;
    if (op_value == 0) begin
      instr_class = CLS_ILLEGAL;
    end else if (op_value == JMP_OP) begin
      instr_class = CLS_JMP;
    end else if (in_range(op_value, BR_LO, BR_HI)) begin
      instr_class = CLS_BR;
    end else if (in_range(op_value, I_LO, I_HI)) begin
      instr_class = CLS_I;
    end else if (in_range(op_value, R_LO, R_HI)) begin
      instr_class = CLS_R;
    end else begin
      instr_class = CLS_ILLEGAL;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Four-state multicycle control FSM: accepts an opcode, decodes it, drives
// execute / write-back controls and counts retired instructions.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int R_LO     = R_LO_DEF,
  parameter int R_HI     = R_HI_DEF,
  parameter int I_LO     = I_LO_DEF,
  parameter int I_HI     = I_HI_DEF,
  parameter int BR_LO    = BR_LO_DEF,
  parameter int BR_HI    = BR_HI_DEF,
  parameter int JMP_OP   = JMP_OP_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                branch_en,
  output logic                jump_en,
  output logic                immediate_en,
  output logic                write_en,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                illegal,
  output logic [CNT_W-1:0]    instr_count
);

  state_t              state;
  state_t              state_nx;
  logic [OPCODE_W-1:0] opcode_q;
  instr_class_t        cls;
  logic                accept;
  logic                retire;

  opcode_classifier #(
    .OPCODE_W (OPCODE_W),
    .R_LO     (R_LO),
    .R_HI     (R_HI),
    .I_LO     (I_LO),
    .I_HI     (I_HI),
    .BR_LO    (BR_LO),
    .BR_HI    (BR_HI),
    .JMP_OP   (JMP_OP)
  ) u_classifier (
    .opcode      (opcode_q),
    .instr_class (cls)
  );

  // State, captured opcode and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      opcode_q    <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        opcode_q <= opcode;
      end
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1'b1);
      end
    end
  end

  // Next state and control outputs; reset forces every output low in the same cycle.
  always_comb begin
    state_nx     = state;
    instr_ready  = 1'b0;
    branch_en    = 1'b0;
    jump_en      = 1'b0;
    immediate_en = 1'b0;
    write_en     = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    illegal      = 1'b0;
    accept       = 1'b0;
    retire       = 1'b0;
    if (rst) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            accept   = 1'b1;
            state_nx = DECODE;
          end else begin
            state_nx = IDLE;
          end
        end
        DECODE: begin
          if (cls == CLS_ILLEGAL) begin
            illegal  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = EXEC;
          end
        end
        EXEC: begin
          immediate_en = (cls == CLS_I);
          branch_en    = (cls == CLS_BR);
          jump_en      = (cls == CLS_JMP);
          case (cls)
            CLS_BR: begin
              pc_load  = branch_taken;
              pc_inc   = ~branch_taken;
              retire   = 1'b1;
              state_nx = IDLE;
            end
            CLS_JMP: begin
              pc_load  = 1'b1;
              retire   = 1'b1;
              state_nx = IDLE;
            end
            CLS_R, CLS_I: begin
              state_nx = WB;
            end
            default: begin
              state_nx = IDLE;
            end
          endcase
        end
        WB: begin
          write_en     = 1'b1;
          immediate_en = (cls == CLS_I);
          // Write-back stalls until memory acknowledges; retire on that same cycle.
          if (mem_ready) begin
            pc_inc   = 1'b1;
            retire   = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = WB;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed plus randomized bench for multicycle_control_unit against an
// instruction-level reference model.
module tb_multicycle_control_unit;

  localparam int K_R   = 0;
  localparam int K_I   = 1;
  localparam int K_BR  = 2;
  localparam int K_JMP = 3;
  localparam int K_ILL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;

  logic        instr_ready, branch_en, jump_en, immediate_en, write_en, pc_inc, pc_load, illegal;
  logic [15:0] instr_count;
  logic        instr_ready4, branch_en4, jump_en4, immediate_en4, write_en4, pc_inc4, pc_load4, illegal4;
  logic [3:0]  instr_count4;

  logic [15:0] model_cnt = 16'd0;
  int          vectors = 0;
  int          miscompares = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .branch_en(branch_en), .jump_en(jump_en), .immediate_en(immediate_en),
    .write_en(write_en), .pc_inc(pc_inc), .pc_load(pc_load), .illegal(illegal),
    .instr_count(instr_count)
  );

  multicycle_control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready4),
    .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .branch_en(branch_en4), .jump_en(jump_en4), .immediate_en(immediate_en4),
    .write_en(write_en4), .pc_inc(pc_inc4), .pc_load(pc_load4), .illegal(illegal4),
    .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference classification straight from the opcode map.
  function automatic int kind_of(input int op);
    if (op == 15) return K_JMP;
    if (op >= 12 && op <= 14) return K_BR;
    if (op >= 9 && op <= 11) return K_I;
    if (op >= 1 && op <= 8) return K_R;
    return K_ILL;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp order: {ready, branch_en, jump_en, immediate_en, write_en, pc_inc, pc_load, illegal}
  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    logic [7:0] obs4;
    #1;
    obs  = {instr_ready, branch_en, jump_en, immediate_en, write_en, pc_inc, pc_load, illegal};
    obs4 = {instr_ready4, branch_en4, jump_en4, immediate_en4, write_en4, pc_inc4, pc_load4, illegal4};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, exp);
    end
    vectors++;
    assert (obs4 === exp) else begin
      miscompares++;
      $error("FAIL %s ctrl4 observed=%b expected=%b", tag, obs4, exp);
    end
    vectors++;
    assert (instr_count === model_cnt) else begin
      miscompares++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, instr_count, model_cnt);
    end
    vectors++;
    assert (instr_count4 === model_cnt[3:0]) else begin
      miscompares++;
      $error("FAIL %s count4 observed=%0d expected=%0d", tag, instr_count4, model_cnt[3:0]);
    end
  endtask

  task automatic idle_cycle();
    instr_valid  = 1'b0;
    opcode       = 4'($urandom);
    mem_ready    = 1'($urandom);
    branch_taken = 1'($urandom);
    check("idle", 8'b1000_0000);
    tick();
  endtask

  // One full instruction from accept to retire (or abandon on reset in write-back).
  task automatic run_instr(input int op, input logic taken, input int wait_n, input logic rst_at_wb);
    int kind;
    kind = kind_of(op);
    instr_valid  = 1'b1;
    opcode       = 4'(op);
    mem_ready    = 1'($urandom);
    branch_taken = 1'($urandom);
    check("accept", 8'b1000_0000);
    tick();
    instr_valid  = 1'($urandom);
    opcode       = 4'($urandom);
    mem_ready    = 1'($urandom);
    branch_taken = 1'($urandom);
    check("decode", {7'b000_0000, kind == K_ILL});
    tick();
    if (kind == K_ILL) return;
    instr_valid  = 1'($urandom);
    branch_taken = taken;
    mem_ready    = 1'($urandom);
    check("exec", {1'b0, kind == K_BR, kind == K_JMP, kind == K_I, 1'b0,
                   kind == K_BR && !taken, kind == K_JMP || (kind == K_BR && taken), 1'b0});
    tick();
    if (kind == K_BR || kind == K_JMP) begin
      model_cnt++;
      return;
    end
    for (int k = 0; k <= wait_n; k++) begin
      if (rst_at_wb) begin
        rst       = 1'b1;
        mem_ready = 1'($urandom);
        check("rst_in_wb", 8'b0000_0000);
        tick();
        model_cnt = 16'd0;
        check("rst_hold", 8'b0000_0000);
        rst = 1'b0;
        return;
      end
      instr_valid  = 1'($urandom);
      mem_ready    = (k == wait_n);
      branch_taken = 1'($urandom);
      check("wb", {3'b000, kind == K_I, 1'b1, k == wait_n, 2'b00});
      tick();
    end
    model_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    check("reset0", 8'b0000_0000);
    tick();
    check("reset1", 8'b0000_0000);
    rst = 1'b0;
    tick();
    idle_cycle();

    run_instr(3, 1'b0, 0, 1'b0);
    idle_cycle();
    run_instr(10, 1'b0, 3, 1'b0);
    run_instr(13, 1'b1, 0, 1'b0);
    run_instr(13, 1'b0, 0, 1'b0);
    run_instr(15, 1'b0, 0, 1'b0);
    run_instr(0, 1'b0, 0, 1'b0);
    idle_cycle();

    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(15, 0)), 1'($urandom), int'($urandom_range(3, 0)), 1'b0);
      if ($urandom_range(3, 0) == 0) idle_cycle();
    end

    run_instr(5, 1'b0, 2, 1'b1);
    idle_cycle();

    for (int n = 0; n < 17; n++) begin
      run_instr(2, 1'b0, 0, 1'b0);
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
